// File: rtl/parameter_bank.sv
// ---------------------------------------------------------------------------
// parameter_bank
//
// Multi-channel synth parameter table fed by decoded MIDI messages. Keeps a
// NUM_CHANNELS x NUM_PARAMS table of values controlled by Control Change
// messages. Values can be 7-bit or 14-bit (MSB/LSB CC pair). An optional slew
// limiter walks each value toward its target. Each entry has a one-cycle
// change strobe.
//
// Ports
//   clock_50_000_000  in   system clock
//   reset             in   asynchronous, active-high reset
//   msg_valid         in   one-cycle strobe, msg_* fields valid
//   msg_status        in   [3:0] message type nibble (0xB = control change)
//   msg_channel       in   [3:0] MIDI channel
//   msg_data1         in   [6:0] CC number
//   msg_data2         in   [6:0] CC value
//   param_value       out  [NE*VW-1:0] entry e = ch*NUM_PARAMS+p at [e*VW +: VW]
//   param_changed     out  [NE-1:0] one-cycle strobe, set when an entry's value changes
// ---------------------------------------------------------------------------
module parameter_bank #(
    parameter int          NUM_CHANNELS  = 4,
    parameter int          NUM_PARAMS    = 8,
    parameter logic [6:0]  CC_BASE       = 7'd20,
    parameter bit          HI_RES        = 1'b1,
    parameter int          DEFAULT_VALUE = 0,
    parameter int          SLEW_STEP     = 0,
    localparam int         VW            = HI_RES ? 14 : 7,
    localparam int         NE            = NUM_CHANNELS * NUM_PARAMS
) (
    input  logic               clock_50_000_000,
    input  logic               reset,
    input  logic               msg_valid,
    input  logic [3:0]         msg_status,
    input  logic [3:0]         msg_channel,
    input  logic [6:0]         msg_data1,
    input  logic [6:0]         msg_data2,
    output logic [NE*VW-1:0]   param_value,
    output logic [NE-1:0]      param_changed
);

    localparam logic [3:0]    CONTROL_CHANGE = 4'hB;
    localparam logic [6:0]    CC_RESET_ALL   = 7'd121;
    localparam logic [VW-1:0] DEFAULT_V      = VW'(DEFAULT_VALUE);

    // Entry state. Target holds the latest requested value. Value is what the
    // outputs show. With no slew, value and target are always equal.
    logic [VW-1:0] target_q [NE];
    logic [VW-1:0] target_d [NE];
    logic [VW-1:0] value_q  [NE];
    logic [NE-1:0] changed_q;

    logic cc_accept;

    assign cc_accept = msg_valid && (msg_status == CONTROL_CHANGE) &&
                       (int'(msg_channel) < NUM_CHANNELS);

    // -----------------------------------------------------------------------
    // Message decode: the next target for every entry.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every entry first takes its current target. Each path through
        // the block then assigns every bit, so no latch is inferred.
        for (int e = 0; e < NE; e++) begin
            target_d[e] = target_q[e];
        end

        if (cc_accept) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (int'(msg_channel) == ch) begin
                    for (int p = 0; p < NUM_PARAMS; p++) begin
                        if (msg_data1 == CC_RESET_ALL) begin
                            target_d[ch*NUM_PARAMS + p] = DEFAULT_V;
                        end else if (msg_data1 == 7'(int'(CC_BASE) + p)) begin
                            // An MSB write clears the low half. A following
                            // LSB write then refines it.
                            if (HI_RES) begin
                                target_d[ch*NUM_PARAMS + p] = VW'({msg_data2, 7'd0});
                            end else begin
                                target_d[ch*NUM_PARAMS + p] = VW'(msg_data2);
                            end
                        end else if (HI_RES &&
                                     (msg_data1 == 7'(int'(CC_BASE) + 32 + p))) begin
                            target_d[ch*NUM_PARAMS + p][6:0] = msg_data2;
                        end
                    end
                end
            end
        end
    end

    // NOTE: the tables are built from flops, not RAM, because every entry
    // must return to DEFAULT_VALUE on reset and on a reset-all CC.
    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < NE; e++) begin
                target_q[e] <= DEFAULT_V;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment. Every
            // reader in this clock domain then sees the pre-edge value.
            for (int e = 0; e < NE; e++) begin
                target_q[e] <= target_d[e];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output value update
    // -----------------------------------------------------------------------
    if (SLEW_STEP == 0) begin : g_direct

        // The value follows the new target on the same edge. The strobe is
        // registered beside it, so both appear together.
        always_ff @(posedge clock_50_000_000 or posedge reset) begin
            if (reset) begin
                for (int e = 0; e < NE; e++) begin
                    value_q[e] <= DEFAULT_V;
                end
                changed_q <= '0;
            end else begin
                for (int e = 0; e < NE; e++) begin
                    value_q[e]   <= target_d[e];
                    changed_q[e] <= (target_d[e] != value_q[e]);
                end
            end
        end

    end else begin : g_slew

        localparam int          SW        = (NE > 1) ? $clog2(NE) : 1;
        localparam int          VW1       = VW + 1;
        localparam int          STEP_CLIP = (SLEW_STEP > (1 << VW)) ? (1 << VW) : SLEW_STEP;
        localparam logic [VW:0] STEP_W    = VW1'(STEP_CLIP);

        logic [SW-1:0] scan_q;
        logic [VW:0]   cur_x;
        logic [VW:0]   tgt_x;
        logic [VW:0]   diff;
        logic [VW-1:0] step_val;

        // One entry is visited per cycle. The visit steps toward the
        // registered target. A message arriving on the same edge only
        // updates the target, so the following visit sees it. The math uses
        // VW+1 bits, and the step is clamped to the remaining distance. It
        // therefore never wraps or overshoots.
        always_comb begin
            cur_x    = {1'b0, value_q[scan_q]};
            tgt_x    = {1'b0, target_q[scan_q]};
            diff     = '0;
            step_val = target_q[scan_q];
            if (tgt_x > cur_x) begin
                diff = tgt_x - cur_x;
                if (diff > STEP_W) begin
                    step_val = VW'(cur_x + STEP_W);
                end
            end else begin
                diff = cur_x - tgt_x;
                if (diff > STEP_W) begin
                    step_val = VW'(cur_x - STEP_W);
                end
            end
        end

        always_ff @(posedge clock_50_000_000 or posedge reset) begin
            if (reset) begin
                for (int e = 0; e < NE; e++) begin
                    value_q[e] <= DEFAULT_V;
                end
                changed_q <= '0;
                scan_q    <= '0;
            end else begin
                changed_q              <= '0;
                value_q[scan_q]        <= step_val;
                changed_q[scan_q]      <= (step_val != value_q[scan_q]);
                scan_q                 <= (scan_q == SW'(NE - 1)) ? '0 : scan_q + 1'b1;
            end
        end

    end

    // -----------------------------------------------------------------------
    // Output packing
    // -----------------------------------------------------------------------
    always_comb begin
        for (int e = 0; e < NE; e++) begin
            param_value[e*VW +: VW] = value_q[e];
        end
    end

    assign param_changed = changed_q;

endmodule

// File: tb/tb_parameter_bank.sv
// ---------------------------------------------------------------------------
// tb_parameter_bank
//
// Bench for three parameter_bank instances. All use 2 channels, 4 params and
// CC_BASE 20.
//   dut_imm : HI_RES=1, no slew
//   dut_slw : HI_RES=1, SLEW_STEP=1024
//   dut_lo  : HI_RES=0, DEFAULT_VALUE=64, no slew
// The instances share the message fields, and each has its own msg_valid.
// ---------------------------------------------------------------------------
module tb_parameter_bank;

    localparam logic [3:0] CC   = 4'hB;
    localparam logic [3:0] NON  = 4'h9;
    localparam logic [3:0] NOFF = 4'h8;

    logic         clk;
    logic         reset;
    logic         valid_imm, valid_slw, valid_lo;
    logic [3:0]   msg_status, msg_channel;
    logic [6:0]   msg_data1, msg_data2;
    logic [111:0] pv_imm, pv_slw;
    logic [55:0]  pv_lo;
    logic [7:0]   pc_imm, pc_slw, pc_lo;

    int checks = 0;
    int errors = 0;

    parameter_bank #(.NUM_CHANNELS(2), .NUM_PARAMS(4), .CC_BASE(7'd20), .HI_RES(1'b1),
                     .DEFAULT_VALUE(0), .SLEW_STEP(0)) dut_imm (
        .clock_50_000_000(clk), .reset(reset), .msg_valid(valid_imm),
        .msg_status(msg_status), .msg_channel(msg_channel), .msg_data1(msg_data1),
        .msg_data2(msg_data2), .param_value(pv_imm), .param_changed(pc_imm));

    parameter_bank #(.NUM_CHANNELS(2), .NUM_PARAMS(4), .CC_BASE(7'd20), .HI_RES(1'b1),
                     .DEFAULT_VALUE(0), .SLEW_STEP(1024)) dut_slw (
        .clock_50_000_000(clk), .reset(reset), .msg_valid(valid_slw),
        .msg_status(msg_status), .msg_channel(msg_channel), .msg_data1(msg_data1),
        .msg_data2(msg_data2), .param_value(pv_slw), .param_changed(pc_slw));

    parameter_bank #(.NUM_CHANNELS(2), .NUM_PARAMS(4), .CC_BASE(7'd20), .HI_RES(1'b0),
                     .DEFAULT_VALUE(64), .SLEW_STEP(0)) dut_lo (
        .clock_50_000_000(clk), .reset(reset), .msg_valid(valid_lo),
        .msg_status(msg_status), .msg_channel(msg_channel), .msg_data1(msg_data1),
        .msg_data2(msg_data2), .param_value(pv_lo), .param_changed(pc_lo));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         tgt;   // 0 imm, 1 slw, 2 lo
        logic       vld;
        logic [3:0] st;
        logic [3:0] ch;
        logic [6:0] d1;
        logic [6:0] d2;
        int         e;     // entry to inspect
        int         v;     // its expected value
        int         mask;  // expected param_changed
    } vec_t;

    typedef struct {
        int tgt;
        int e;
        int v;
        int mask;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int get_val(input int tgt, input int e);
        case (tgt)
            0:       return int'(pv_imm[e*14 +: 14]);
            1:       return int'(pv_slw[e*14 +: 14]);
            default: return int'(pv_lo[e*7 +: 7]);
        endcase
    endfunction

    function automatic int get_mask(input int tgt);
        case (tgt)
            0:       return int'(pc_imm);
            1:       return int'(pc_slw);
            default: return int'(pc_lo);
        endcase
    endfunction

    task automatic set_msg(input int tgt, input logic vld, input logic [3:0] st,
                           input logic [3:0] ch, input logic [6:0] d1, input logic [6:0] d2);
        msg_status  = st;
        msg_channel = ch;
        msg_data1   = d1;
        msg_data2   = d2;
        valid_imm   = vld && (tgt == 0);
        valid_slw   = vld && (tgt == 1);
        valid_lo    = vld && (tgt == 2);
    endtask

    task automatic idle_msg();
        valid_imm = 1'b0;
        valid_slw = 1'b0;
        valid_lo  = 1'b0;
    endtask

    // Follows entry 0 of dut_slw toward goal, checking each step and the
    // spacing between visits.
    task automatic run_ramp(input int goal, input int budget, output int n_steps);
        int prev, cur, last_cyc, expn, d;
        prev     = get_val(1, 0);
        n_steps  = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < budget && prev != goal; cyc++) begin
            @(negedge clk);
            cur = get_val(1, 0);
            check("ramp_strobe_with_change", int'(pc_slw[0]), int'(cur != prev));
            check("ramp_other_strobes", int'(pc_slw[7:1]), 0);
            if (cur != prev) begin
                d    = goal - prev;
                expn = (d > 1024) ? prev + 1024 : ((d < -1024) ? prev - 1024 : goal);
                check("ramp_step", cur, expn);
                if (n_steps > 0) check("ramp_visit_period", cyc - last_cyc, 8);
                last_cyc = cyc;
                n_steps++;
            end
            prev = cur;
        end
        check("ramp_reached_goal", prev, goal);
    endtask

    initial begin
        int n;
        int found;
        int final_imm[8];
        exp_t x;

        reset = 1'b1;
        idle_msg();
        set_msg(0, 1'b0, 4'h0, 4'h0, 7'd0, 7'd0);

        // ---- idle after reset ----
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_zero_values", int'((|pv_imm) | (|pv_slw)), 0);
            check("idle_no_strobes", int'(|{pc_imm, pc_slw, pc_lo}), 0);
        end
        for (int e = 0; e < 8; e++) check("lo_default_value", get_val(2, e), 64);

        // ---- table ----
        vecs.push_back('{0, 1'b1, CC,   4'd0, 7'd21,  7'd10,  1, 1280,  'h02});
        vecs.push_back('{0, 1'b1, CC,   4'd0, 7'd53,  7'd5,   1, 1285,  'h02});
        vecs.push_back('{0, 1'b1, CC,   4'd0, 7'd53,  7'd5,   1, 1285,  'h00});
        vecs.push_back('{0, 1'b1, CC,   4'd5, 7'd20,  7'd99,  0, 0,     'h00});
        vecs.push_back('{0, 1'b1, NON,  4'd0, 7'd10,  7'd80,  1, 1285,  'h00});
        vecs.push_back('{0, 1'b1, NON,  4'd0, 7'd20,  7'd80,  0, 0,     'h00});
        vecs.push_back('{0, 1'b1, NOFF, 4'd0, 7'd30,  7'd0,   1, 1285,  'h00});
        vecs.push_back('{0, 1'b1, CC,   4'd0, 7'd30,  7'd7,   0, 0,     'h00});
        vecs.push_back('{0, 1'b0, CC,   4'd0, 7'd20,  7'd50,  0, 0,     'h00});
        vecs.push_back('{0, 1'b1, CC,   4'd1, 7'd20,  7'd1,   4, 128,   'h10});
        vecs.push_back('{0, 1'b1, CC,   4'd1, 7'd21,  7'd2,   5, 256,   'h20});
        vecs.push_back('{0, 1'b1, CC,   4'd1, 7'd22,  7'd3,   6, 384,   'h40});
        vecs.push_back('{0, 1'b1, CC,   4'd1, 7'd55,  7'd127, 7, 127,   'h80});
        vecs.push_back('{0, 1'b1, CC,   4'd0, 7'd23,  7'd127, 3, 16256, 'h08});
        vecs.push_back('{0, 1'b1, CC,   4'd0, 7'd55,  7'd127, 3, 16383, 'h08});
        vecs.push_back('{0, 1'b1, CC,   4'd1, 7'd121, 7'd0,   4, 0,     'hF0});
        vecs.push_back('{0, 1'b1, CC,   4'd0, 7'd21,  7'd10,  1, 1280,  'h02});
        vecs.push_back('{0, 1'b1, CC,   4'd1, 7'd121, 7'd0,   5, 0,     'h00});
        vecs.push_back('{0, 1'b1, CC,   4'd2, 7'd20,  7'd5,   0, 0,     'h00});
        vecs.push_back('{0, 1'b1, CC,   4'd0, 7'd22,  7'd0,   2, 0,     'h00});
        vecs.push_back('{0, 1'b1, CC,   4'd0, 7'd52,  7'd9,   0, 9,     'h01});
        vecs.push_back('{2, 1'b1, CC,   4'd0, 7'd20,  7'd100, 0, 100,   'h01});
        vecs.push_back('{2, 1'b1, CC,   4'd0, 7'd52,  7'd5,   0, 100,   'h00});
        vecs.push_back('{2, 1'b1, CC,   4'd1, 7'd23,  7'd64,  7, 64,    'h00});
        vecs.push_back('{2, 1'b1, CC,   4'd1, 7'd20,  7'd0,   4, 0,     'h10});
        vecs.push_back('{2, 1'b1, CC,   4'd0, 7'd121, 7'd0,   0, 64,    'h01});

        foreach (vecs[i]) begin
            @(negedge clk);
            set_msg(vecs[i].tgt, vecs[i].vld, vecs[i].st, vecs[i].ch, vecs[i].d1, vecs[i].d2);
            sb.push_back('{vecs[i].tgt, vecs[i].e, vecs[i].v, vecs[i].mask});
            @(negedge clk);
            idle_msg();
            x = sb.pop_front();
            check($sformatf("vec%0d_value", i), get_val(x.tgt, x.e), x.v);
            check($sformatf("vec%0d_strobe", i), get_mask(x.tgt), x.mask);
            @(negedge clk);
            check($sformatf("vec%0d_strobe_one_cycle", i), get_mask(x.tgt), 0);
        end

        final_imm = '{9, 1280, 0, 16383, 0, 0, 0, 0};
        for (int e = 0; e < 8; e++) check($sformatf("imm_final_e%0d", e), get_val(0, e), final_imm[e]);
        check("lo_e4_kept", get_val(2, 4), 0);

        // ---- back-to-back messages, then reset-all on ch0 ----
        @(negedge clk);
        set_msg(0, 1'b1, CC, 4'd0, 7'd20, 7'd1);
        @(negedge clk);
        check("b2b_first_value", get_val(0, 0), 128);
        check("b2b_first_strobe", get_mask(0), 'h01);
        set_msg(0, 1'b1, CC, 4'd0, 7'd21, 7'd2);
        @(negedge clk);
        idle_msg();
        check("b2b_second_value", get_val(0, 1), 256);
        check("b2b_second_strobe", get_mask(0), 'h02);
        @(negedge clk);
        set_msg(0, 1'b1, CC, 4'd0, 7'd121, 7'd0);
        @(negedge clk);
        idle_msg();
        check("ch0_reset_all_strobes", get_mask(0), 'h0B);
        check("ch0_reset_all_values", int'(|pv_imm), 0);

        // ---- slew ----
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_msg(1, 1'b1, CC, 4'd0, 7'd20, 7'd127);
        @(negedge clk);
        idle_msg();
        run_ramp(16256, 200, n);
        check("ramp_up_steps", n, 16);

        @(negedge clk);
        set_msg(1, 1'b1, CC, 4'd0, 7'd20, 7'd0);
        @(negedge clk);
        idle_msg();
        run_ramp(0, 200, n);
        check("ramp_down_steps", n, 16);

        // Write that lands on the same edge as a visit to entry 0.
        @(negedge clk);
        set_msg(1, 1'b1, CC, 4'd0, 7'd20, 7'd127);
        @(negedge clk);
        idle_msg();
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (get_val(1, 0) == 4096) found = 1;
        end
        check("collide_reached_4096", found, 1);
        repeat (6) @(negedge clk);
        @(negedge clk);
        set_msg(1, 1'b1, CC, 4'd0, 7'd20, 7'd0);
        @(negedge clk);
        idle_msg();
        check("collide_steps_to_old_target", get_val(1, 0), 5120);
        check("collide_strobe", int'(pc_slw[0]), 1);
        repeat (8) @(negedge clk);
        check("collide_then_new_target", get_val(1, 0), 4096);
        run_ramp(0, 100, n);
        check("collide_ramp_down_steps", n, 4);

        // Reset mid-ramp.
        @(negedge clk);
        set_msg(1, 1'b1, CC, 4'd0, 7'd20, 7'd127);
        @(negedge clk);
        idle_msg();
        repeat (30) @(negedge clk);
        check("mid_ramp_nonzero", int'(get_val(1, 0) > 0), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_value", int'(|pv_slw), 0);
        check("async_reset_strobe", int'(pc_slw), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("post_reset_quiet", int'((|pv_slw) | (|pc_slw)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
